// File: rtl/btn_conditioner.sv
// Purpose: push-button conditioner with a 2-flop synchronizer, a counter debouncer and a press/release FSM per channel.
// Latency: a raw change sampled at edge 0 reaches pressed/press_pulse/release_pulse at edge DEBOUNCE_CYCLES+2.
// Backpressure: none; the outputs are free-running levels and one-cycle strobes. Optional macro: BTN_CONDITIONER_REPEAT_EN (auto-repeat).
module btn_conditioner #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BTN_ACTIVE_LOW  = 1,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] pressed,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse
);

    localparam int                 CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic               POL     = (BTN_ACTIVE_LOW != 0);
    localparam logic [N_BTN-1:0]   REL_LVL = {N_BTN{POL}};

    // A debounce window below two cycles or a zero repeat interval is meaningless.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("btn_conditioner: illegal parameter value");
    end

`ifdef BTN_CONDITIONER_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD - 1);
    typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;
`else
    typedef enum logic {IDLE, HELD} state_t;
`endif

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] act;

    // Two-flop synchronizer; reset loads the released level so no false edge appears at reset exit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= REL_LVL;
            sync2 <= REL_LVL;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Normalize polarity so 1 always means held down.
    assign act = sync2 ^ REL_LVL;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        logic [CNT_W-1:0] cnt;
        logic             level;
        state_t           state;
        state_t           state_n;
        logic             press_n;
        logic             rel_n;
        logic             pressed_q;
        logic             press_q;
        logic             rel_q;
`ifdef BTN_CONDITIONER_REPEAT_EN
        logic [RPT_W-1:0] rcnt;
        logic [RPT_W-1:0] rcnt_n;
`endif

        // Debouncer: a new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt   <= '0;
                level <= 1'b0;
            end else if (act[i] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= act[i];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        // Next-state and strobe decode; a release always wins over a repeat in the same cycle.
        always_comb begin
            state_n = state;
            press_n = 1'b0;
            rel_n   = 1'b0;
`ifdef BTN_CONDITIONER_REPEAT_EN
            rcnt_n  = rcnt;
`endif
            case (state)
                IDLE: begin
                    if (level) begin
                        state_n = HELD;
                        press_n = 1'b1;
`ifdef BTN_CONDITIONER_REPEAT_EN
                        rcnt_n  = '0;
`endif
                    end
                end
                HELD: begin
                    if (!level) begin
                        state_n = IDLE;
                        rel_n   = 1'b1;
`ifdef BTN_CONDITIONER_REPEAT_EN
                        rcnt_n  = '0;
                    end else if (rcnt == DLY_LAST) begin
                        state_n = REPEAT;
                        press_n = 1'b1;
                        rcnt_n  = '0;
                    end else begin
                        rcnt_n  = rcnt + RPT_W'(1);
`endif
                    end
                end
`ifdef BTN_CONDITIONER_REPEAT_EN
                REPEAT: begin
                    if (!level) begin
                        state_n = IDLE;
                        rel_n   = 1'b1;
                        rcnt_n  = '0;
                    end else if (rcnt == PER_LAST) begin
                        press_n = 1'b1;
                        rcnt_n  = '0;
                    end else begin
                        rcnt_n  = rcnt + RPT_W'(1);
                    end
                end
`endif
                default: state_n = IDLE;
            endcase
        end

        // State and registered outputs.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state     <= IDLE;
                pressed_q <= 1'b0;
                press_q   <= 1'b0;
                rel_q     <= 1'b0;
`ifdef BTN_CONDITIONER_REPEAT_EN
                rcnt      <= '0;
`endif
            end else begin
                state     <= state_n;
                pressed_q <= (state_n != IDLE);
                press_q   <= press_n;
                rel_q     <= rel_n;
`ifdef BTN_CONDITIONER_REPEAT_EN
                rcnt      <= rcnt_n;
`endif
            end
        end

        assign pressed[i]       = pressed_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = rel_q;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Purpose: self-checking bench for btn_conditioner with an event scoreboard of expected pulses.
// Latency: expected pulses are timestamped 7 negedges after the drive point (edge 0 + 6).
// Backpressure: none; the bench drives and samples on the falling edge.
module tb_btn_conditioner;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] btn_raw;
    logic [N-1:0] pressed;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    typedef struct {
        int cyc;
        int ch;
        bit is_press;
    } ev_t;

    ev_t q[$];

    btn_conditioner #(
        .N_BTN(N),
        .DEBOUNCE_CYCLES(4),
        .BTN_ACTIVE_LOW(1),
        .REPEAT_DELAY(20),
        .REPEAT_PERIOD(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .btn_raw(btn_raw),
        .pressed(pressed),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Queue an expected pulse lat negedges after the current one.
    task automatic expect_ev(input int ch, input bit is_press, input int lat);
        ev_t e;
        e.cyc      = cyc + lat;
        e.ch       = ch;
        e.is_press = is_press;
        q.push_back(e);
    endtask

    function automatic longint enc(input int c, input int ch, input bit p);
        return longint'(c) * 100 + ch * 10 + (p ? 1 : 0);
    endfunction

    // Scoreboard: every observed pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if ((press_pulse & release_pulse) != '0)
            check_val("both_pulses", longint'(press_pulse & release_pulse), 0);
        for (int ch = 0; ch < N; ch++) begin
            if (press_pulse[ch] || release_pulse[ch]) begin
                if (q.size() == 0) begin
                    check_val("unexpected", enc(cyc, ch, press_pulse[ch]), 0);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    check_val("event", enc(cyc, ch, press_pulse[ch]), enc(e.cyc, e.ch, e.is_press));
                end
            end
        end
        if (q.size() != 0 && q[0].cyc < cyc) begin
            check_val("missed", enc(cyc, q[0].ch, q[0].is_press), enc(q[0].cyc, q[0].ch, q[0].is_press));
            void'(q.pop_front());
        end
    end

    initial begin
        reset_n = 1'b0;
        btn_raw = '1;
        tick(3);
        check_val("rst_pressed", pressed, 0);
        check_val("rst_press_pulse", press_pulse, 0);
        check_val("rst_release_pulse", release_pulse, 0);
        reset_n = 1'b1;
        tick(10);
        check_val("idle_pressed", pressed, 0);

        // Clean press on channel 1, then release.
        btn_raw[1] = 1'b0;
        expect_ev(1, 1'b1, 7);
        tick(6);
        check_val("t1_before", pressed, 0);
        tick(1);
        check_val("t1_pressed", pressed, 4'b0010);
        tick(3);
        btn_raw[1] = 1'b1;
        expect_ev(1, 1'b0, 7);
        tick(7);
        check_val("t1_released", pressed, 0);
        tick(3);

        // Bounce on channel 2: low 3, high 1, ten times.
        for (int k = 0; k < 10; k++) begin
            btn_raw[2] = 1'b0;
            tick(3);
            btn_raw[2] = 1'b1;
            tick(1);
        end
        tick(10);
        check_val("t2_pressed", pressed, 0);

        // Long hold on channel 0, release edge timing.
        btn_raw[0] = 1'b0;
        expect_ev(0, 1'b1, 7);
        tick(20);
        check_val("t3_held", pressed, 4'b0001);
        btn_raw[0] = 1'b1;
        expect_ev(0, 1'b0, 7);
        tick(6);
        check_val("t3_still_held", pressed, 4'b0001);
        tick(1);
        check_val("t3_released", pressed, 0);
        tick(3);

        // Simultaneous press and release on all channels.
        btn_raw = '0;
        for (int ch = 0; ch < N; ch++) expect_ev(ch, 1'b1, 7);
        tick(7);
        check_val("t4_pressed", pressed, 4'b1111);
        btn_raw = '1;
        for (int ch = 0; ch < N; ch++) expect_ev(ch, 1'b0, 7);
        tick(7);
        check_val("t4_released", pressed, 0);
        tick(3);

        // Reset mid-hold (ch0) and mid-count (ch3).
        btn_raw[0] = 1'b0;
        expect_ev(0, 1'b1, 7);
        tick(10);
        check_val("t5_pre_pressed", pressed, 4'b0001);
        btn_raw[3] = 1'b0;
        tick(4);
        reset_n = 1'b0;
        #1;
        check_val("t5_rst_pressed", pressed, 0);
        check_val("t5_rst_press_pulse", press_pulse, 0);
        check_val("t5_rst_release_pulse", release_pulse, 0);
        btn_raw[0] = 1'b1;
        tick(2);
        reset_n = 1'b1;
        expect_ev(3, 1'b1, 7);
        tick(6);
        check_val("t5_before", pressed, 0);
        tick(1);
        check_val("t5_pressed", pressed, 4'b1000);
        btn_raw[3] = 1'b1;
        expect_ev(3, 1'b0, 7);
        tick(10);
        check_val("t5_released", pressed, 0);

`ifdef BTN_CONDITIONER_REPEAT_EN
        // Auto-repeat: acceptance, then +20, +28, +36, +44, +52, then one release.
        btn_raw[0] = 1'b0;
        expect_ev(0, 1'b1, 7);
        for (int k = 0; k < 5; k++) expect_ev(0, 1'b1, 27 + 8 * k);
        tick(60);
        check_val("t6_held", pressed, 4'b0001);
        btn_raw[0] = 1'b1;
        expect_ev(0, 1'b0, 7);
        tick(12);
        check_val("t6_released", pressed, 0);
`endif

        tick(5);
        check_val("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
